snes_clkgen: RTL and testbench



---
 rtl/snes_clkgen_if.sv | 21 ++
 rtl/snes_clkgen.sv | 123 ++++++++++++
 tb/tb_snes_clkgen.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/snes_clkgen_if.sv
// snes_clkgen_if: control inputs and clock-enable outputs of the SNES master-clock sequencer
interface snes_clkgen_if;
  logic        pll_lock;
  logic        pause;
  logic [1:0]  cpu_speed;
  logic        sys_rst_n;
  logic        cpu_ce;
  logic        cpu_phi2;
  logic        refresh;
  logic        dot_ce;
  logic [10:0] hpos;
  logic        apu_ce;
  modport master (
    output pll_lock, pause, cpu_speed,
    input  sys_rst_n, cpu_ce, cpu_phi2, refresh, dot_ce, hpos, apu_ce
  );
  modport slave (
    input  pll_lock, pause, cpu_speed,
    output sys_rst_n, cpu_ce, cpu_phi2, refresh, dot_ce, hpos, apu_ce
  );
endinterface

// File: rtl/snes_clkgen.sv
// snes_clkgen: PLL-lock power-on reset plus CPU/PPU/APU clock enables on the SNES master clock
module snes_clkgen #(
  parameter int POR_CYCLES  = 2048,
  parameter int REFRESH_POS = 536,
  parameter int REFRESH_LEN = 40
) (
  input logic          clk,
  input logic          resetn,
  snes_clkgen_if.slave bus
);
  localparam int PW = $clog2(POR_CYCLES + 1);
  localparam int SW = $clog2(REFRESH_LEN + 1);
  localparam logic [PW-1:0] POR_MAX = PW'(POR_CYCLES - 1);
  typedef enum logic {S_RUN, S_STALL} state_t;
  state_t        r_state, w_state;
  logic [1:0]    r_sync;
  logic [PW-1:0] r_por;
  logic          r_rst_n;
  logic [3:0]    r_cnt, w_cnt, r_len, w_len, w_len_cur;
  logic [SW-1:0] r_stall, w_stall;
  logic          r_pend, w_pend;
  logic [10:0]   r_hpos, w_hpos;
  logic [9:0]    r_acc, w_acc;
  logic [10:0]   w_sum;
  logic          r_cpu_ce, w_cpu_ce, r_phi2, w_phi2, r_refresh, w_refresh, r_apu_ce, w_apu_ce;
  logic          w_run, w_end, w_pend_now;
  // Cycle length is taken live from cpu_speed only on the first clock of a cycle
  always_comb begin
    w_run      = r_rst_n & ~bus.pause;
    w_len_cur  = (r_cnt == 4'd0) ? (bus.cpu_speed == 2'd0 ? 4'd6 : bus.cpu_speed == 2'd2 ? 4'd12 : 4'd8) : r_len;
    w_end      = r_cnt == w_len_cur - 4'd1;
    w_pend_now = r_pend | (r_hpos == 11'(REFRESH_POS));
    w_sum      = {1'b0, r_acc} + 11'd32;
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_len      = r_len;
    w_stall    = r_stall;
    w_pend     = r_pend;
    w_hpos     = r_hpos;
    w_acc      = r_acc;
    w_cpu_ce   = 1'b0;
    w_apu_ce   = 1'b0;
    w_phi2     = r_phi2;
    w_refresh  = r_refresh;
    if (!r_rst_n) begin
      w_state   = S_RUN;
      w_cnt     = '0;
      w_len     = '0;
      w_stall   = '0;
      w_pend    = 1'b0;
      w_hpos    = '0;
      w_acc     = '0;
      w_phi2    = 1'b0;
      w_refresh = 1'b0;
    end else if (w_run) begin
      w_hpos   = (r_hpos == 11'd1363) ? 11'd0 : r_hpos + 11'd1;
      w_apu_ce = w_sum >= 11'd675;
      w_acc    = w_apu_ce ? 10'(w_sum - 11'd675) : w_sum[9:0];
      if (r_state == S_STALL) begin
        w_refresh = 1'b1;
        w_phi2    = 1'b0;
        w_stall   = r_stall + SW'(1);
        if (r_stall == SW'(REFRESH_LEN - 1)) begin
          w_state = S_RUN;
          w_pend  = 1'b0;
          w_stall = '0;
          w_cnt   = '0;
        end
      end else begin
        w_pend    = w_pend_now;
        w_len     = w_len_cur;
        w_refresh = 1'b0;
        w_cpu_ce  = w_end;
        w_phi2    = r_cnt >= w_len_cur - 4'd4;
        w_cnt     = w_end ? 4'd0 : r_cnt + 4'd1;
        if (w_end && w_pend_now) begin
          w_state = S_STALL;
          w_stall = '0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync    <= '0;
      r_por     <= '0;
      r_rst_n   <= 1'b0;
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_len     <= '0;
      r_stall   <= '0;
      r_pend    <= 1'b0;
      r_hpos    <= '0;
      r_acc     <= '0;
      r_cpu_ce  <= 1'b0;
      r_phi2    <= 1'b0;
      r_refresh <= 1'b0;
      r_apu_ce  <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], bus.pll_lock};
      r_por     <= !r_sync[1] ? '0 : (r_por == POR_MAX) ? r_por : r_por + PW'(1);
      r_rst_n   <= r_sync[1] && r_por == POR_MAX;
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_len     <= w_len;
      r_stall   <= w_stall;
      r_pend    <= w_pend;
      r_hpos    <= w_hpos;
      r_acc     <= w_acc;
      r_cpu_ce  <= w_cpu_ce;
      r_phi2    <= w_phi2;
      r_refresh <= w_refresh;
      r_apu_ce  <= w_apu_ce;
    end
  end
  assign bus.sys_rst_n = r_rst_n;
  assign bus.cpu_ce    = r_cpu_ce;
  assign bus.cpu_phi2  = r_phi2;
  assign bus.refresh   = r_refresh;
  assign bus.dot_ce    = w_run & (r_hpos[1:0] == 2'b11);
  assign bus.hpos      = r_hpos;
  assign bus.apu_ce    = r_apu_ce;
endmodule

// File: tb/tb_snes_clkgen.sv
// tb_snes_clkgen: directed tables plus randomized run checked against a closed-form reference model
module tb_snes_clkgen;
  localparam int POR = 16;
  typedef struct { logic [1:0] sp; int period; int phi; } speed_vec_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  snes_clkgen_if ifc();
  snes_clkgen #(.POR_CYCLES(POR), .REFRESH_POS(536), .REFRESH_LEN(40)) dut (
    .clk(clk), .resetn(resetn), .bus(ifc)
  );
  int vectors = 0;
  int miscompares = 0;
  bit m_valid = 0;
  bit m_rst, m_pend, e_ce, e_phi2, e_ref, e_apu;
  int o0, o1, o2, m_left, m_stall, e_hpos;
  longint m_n;
  bit g_lk, g_ps, g_dot;
  logic [1:0] g_sp;
  speed_vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_n = 0; m_left = 0; m_stall = 0; m_pend = 0;
    e_phi2 = 0; e_ref = 0; e_hpos = 0;
  endtask

  // Reference: lock history decides reset; hpos and apu pulses follow from the run-clock count
  task automatic model_step(input bit rn, input bit lk, input bit ps, input logic [1:0] sp);
    longint h;
    e_ce = 0; e_apu = 0;
    if (!rn) begin
      m_rst = 0; o0 = 0; o1 = 0; o2 = 0;
      model_clear();
      return;
    end
    if (!m_rst) model_clear();
    else if (!ps) begin
      h = m_n % 1364;
      m_n++;
      e_hpos = int'(m_n % 1364);
      e_apu = (32 * m_n) / 675 != (32 * (m_n - 1)) / 675;
      if (m_stall > 0) begin
        e_ref = 1; e_phi2 = 0;
        m_stall--;
        if (m_stall == 0) m_pend = 0;
      end else begin
        if (h == 536) m_pend = 1;
        if (m_left == 0) m_left = (sp == 2'd0) ? 6 : (sp == 2'd2) ? 12 : 8;
        e_phi2 = m_left <= 4;
        m_left--;
        e_ce = m_left == 0;
        e_ref = 0;
        if (e_ce && m_pend) m_stall = 40;
      end
    end
    o2 = o1; o1 = o0;
    o0 = lk ? (o0 < 1000 ? o0 + 1 : o0) : 0;
    m_rst = o2 >= POR;
  endtask

  task automatic check_model(input bit ps);
    logic [17:0] got, want;
    got  = {ifc.sys_rst_n, ifc.cpu_ce, ifc.cpu_phi2, ifc.refresh, ifc.dot_ce, ifc.apu_ce, 1'b0, ifc.hpos};
    want = {m_rst, e_ce, e_phi2, e_ref, m_rst && !ps && (e_hpos % 4 == 3), e_apu, 1'b0, 11'(e_hpos)};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL model @%0t: got rst_n,ce,phi2,ref,dot,apu,0,hpos=%b want %b", $time, got, want);
    end
  endtask

  task automatic tick(input bit rn, input bit lk, input bit ps, input logic [1:0] sp);
    resetn = rn; ifc.pll_lock = lk; ifc.pause = ps; ifc.cpu_speed = sp;
    #1;
    g_dot = ifc.dot_ce;
    if (m_valid) check_model(ps);
    @(posedge clk);
    model_step(rn, lk, ps, sp);
    if (!rn) m_valid = 1;
    @(negedge clk);
  endtask

  task automatic st();
    tick(1'b1, g_lk, g_ps, g_sp);
  endtask

  task automatic wait_ce(output int n, output int ph);
    n = 0; ph = 0;
    do begin
      st();
      n++;
      ph += int'(ifc.cpu_phi2);
    end while (!ifc.cpu_ce && n < 200);
    if (!ifc.cpu_ce) chk("ce_timeout", n, -1);
  endtask

  initial begin
    int c, n, ph, mn, mph, last, apuc, mingap, cnt48, odd, refc, dotc, pulses, h0;
    bit lo;
    tbl[0] = '{2'd0, 6, 4};
    tbl[1] = '{2'd1, 8, 4};
    tbl[2] = '{2'd2, 12, 4};
    tbl[3] = '{2'd3, 8, 4};
    g_lk = 0; g_ps = 0; g_sp = 2'd0;
    @(negedge clk);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset_rst_n", int'(ifc.sys_rst_n), 0);
    chk("reset_hpos", int'(ifc.hpos), 0);
    repeat (5) st();
    chk("nolock_rst_n", int'(ifc.sys_rst_n), 0);
    g_lk = 1; c = 0;
    while (!ifc.sys_rst_n && c < 100) begin st(); c++; end
    chk("por_latency", c, POR + 2);
    // APU rate from a fresh release
    apuc = 0; last = -1; mingap = 1000;
    for (int i = 1; i <= 21600; i++) begin
      st();
      if (ifc.apu_ce) begin
        apuc++;
        if (last >= 0 && i - last < mingap) mingap = i - last;
        last = i;
      end
      if (i == 675) chk("apu_675", apuc, 32);
    end
    chk("apu_21600", apuc, 1024);
    chk("apu_min_gap_ge21", int'(mingap >= 21), 1);
    // Single-clock lock drop
    g_lk = 0; st(); g_lk = 1; c = 0; lo = 0;
    while (c < 100 && !(lo && ifc.sys_rst_n)) begin
      st(); c++;
      if (!ifc.sys_rst_n && !lo) begin lo = 1; chk("lock_loss_latency", c, 2); end
    end
    chk("lock_loss_seen", int'(lo), 1);
    chk("lock_return_latency", c, POR + 2);
    // Speed switch 0 -> 2 at cnt = 3
    g_sp = 2'd0;
    wait_ce(n, ph); chk("first_cycle_len", n, 6);
    repeat (3) st();
    g_sp = 2'd2;
    wait_ce(n, ph); chk("switch_cur_len", n + 3, 6);
    wait_ce(n, ph); chk("switch_next_len", n, 12);
    foreach (tbl[k]) begin
      g_sp = tbl[k].sp;
      wait_ce(n, ph);
      mn = 1000; mph = -1;
      for (int j = 0; j < 4; j++) begin
        wait_ce(n, ph);
        if (n < mn) begin mn = n; mph = ph; end
      end
      chk($sformatf("period_sp%0d", k), mn, tbl[k].period);
      chk($sformatf("phi2_hi_sp%0d", k), mph, tbl[k].phi);
    end
    // One full line at speed 1
    g_sp = 2'd1; c = 0;
    while (ifc.hpos != 11'd0 && c < 1400) begin st(); c++; end
    chk("line_sync", int'(ifc.hpos), 0);
    last = -1; cnt48 = 0; odd = 0; refc = 0; dotc = 0;
    for (int i = 1; i <= 1364; i++) begin
      st();
      refc += int'(ifc.refresh);
      dotc += int'(g_dot);
      if (ifc.cpu_ce) begin
        if (last >= 0) begin
          if (i - last == 48) cnt48++;
          else if (i - last != 8) odd++;
        end
        last = i;
      end
    end
    chk("line_gap48", cnt48, 1);
    chk("line_other_gaps", odd, 0);
    chk("line_refresh_len", refc, 40);
    chk("line_dot_count", dotc, 341);
    // Pause in the middle of a stall
    c = 0;
    while (!ifc.refresh && c < 1500) begin st(); c++; end
    chk("stall_found", int'(ifc.refresh), 1);
    repeat (5) st();
    h0 = int'(ifc.hpos); g_ps = 1; pulses = 0;
    repeat (100) begin
      st();
      pulses += int'(ifc.cpu_ce) + int'(ifc.apu_ce) + int'(g_dot);
    end
    chk("pause_hpos", int'(ifc.hpos), h0);
    chk("pause_pulses", pulses, 0);
    chk("pause_refresh_held", int'(ifc.refresh), 1);
    g_ps = 0; c = 0;
    while (ifc.refresh && c < 100) begin st(); c++; end
    chk("pause_stall_rest", c, 35);
    repeat (200) st();
    // Reset in the middle of a 12-clock cycle
    g_sp = 2'd2;
    wait_ce(n, ph);
    repeat (4) st();
    tick(1'b0, 1'b1, 1'b0, 2'd2);
    chk("rst_mid_flags", int'({ifc.sys_rst_n, ifc.cpu_ce, ifc.cpu_phi2, ifc.refresh, ifc.apu_ce}), 0);
    chk("rst_mid_hpos", int'(ifc.hpos), 0);
    c = 0;
    while (!ifc.sys_rst_n && c < 100) begin st(); c++; end
    chk("rst_mid_por", c, POR + 2);
    // Randomized run against the model
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(39) == 0) g_ps = ~g_ps;
      if ($urandom_range(59) == 0) g_sp = 2'($urandom_range(3));
      if ($urandom_range(3999) == 0) tick(1'b0, g_lk, g_ps, g_sp);
      else if ($urandom_range(4999) == 0) tick(1'b1, 1'b0, g_ps, g_sp);
      else st();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
